// File: rtl/md_pkg.sv
// Shared types and funct3 decode helpers for the RV32M multi-cycle multiply/divide sequencer.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/md_core.sv
// Iterative datapath: one shared W+1 bit adder/subtractor drives either a shift-add multiply
// or a restoring divide on unsigned magnitudes; hi/lo hold product or remainder/quotient.
module md_core #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         isDiv,
    input  logic [W-1:0] magA,
    input  logic [W-1:0] magB,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [W-1:0] hi_q, lo_q, b_q;
    logic [W-1:0] hi_d, lo_d;
    logic [W:0]   addX, addY;
    logic [W+1:0] sum;
    logic         noBorrow;

    // Divide subtracts B from the shifted partial remainder; multiply adds B when the multiplier LSB is set.
    always_comb begin
        addX     = isDiv ? {hi_q, lo_q[W-1]} : {1'b0, hi_q};
        addY     = (isDiv || lo_q[0]) ? {1'b0, b_q} : '0;
        sum      = {1'b0, addX} + {1'b0, (isDiv ? ~addY : addY)} + {{(W+1){1'b0}}, isDiv};
        noBorrow = sum[W+1];
        if (isDiv) begin
            hi_d = noBorrow ? sum[W-1:0] : addX[W-1:0];
            lo_d = {lo_q[W-2:0], noBorrow};
        end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= magA;
            b_q  <= magB;
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: latches operands on start, iterates DWIDTH cycles in md_core,
// sign-corrects in FIX and pulses done with the registered result; stalls the pipeline meanwhile.
module muldiv_seq
    import md_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DWIDTH-1:0] opa,
    input  logic [DWIDTH-1:0] opb,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] result
);

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    md_state_t         state_q;
    logic [2:0]        f3_q;
    logic              signA_q, signB_q;
    logic [CW-1:0]     count_q;
    logic [DWIDTH-1:0] result_q;

    logic                accept, signA, signB, divZero, overflow, stepEn, coreDiv;
    logic [DWIDTH-1:0]   magA, magB, fastRes, fixRes, quotFix, remFix, hi, lo;
    logic [2*DWIDTH-1:0] prodFix;

    // Operand magnitudes and the divide corner cases that bypass iteration entirely.
    always_comb begin
        accept   = start && (state_q == IDLE);
        signA    = is_signed_a(funct3) && opa[DWIDTH-1];
        signB    = is_signed_b(funct3) && opb[DWIDTH-1];
        magA     = signA ? -opa : opa;
        magB     = signB ? -opb : opb;
        divZero  = is_div(funct3) && (opb == '0);
        overflow = is_div(funct3) && is_signed_a(funct3) && (opa == MIN_NEG) && (opb == '1);
        if (divZero) begin
            fastRes = funct3[1] ? opa : '1;
        end else begin
            fastRes = funct3[1] ? '0 : MIN_NEG;
        end
        stepEn  = (state_q == CALC);
        coreDiv = is_div(f3_q);
    end

    md_core #(.W(DWIDTH)) u_core (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .step  (stepEn),
        .isDiv (coreDiv),
        .magA  (magA),
        .magB  (magB),
        .hi    (hi),
        .lo    (lo)
    );

    always_comb begin
        prodFix = (signA_q ^ signB_q) ? -{hi, lo} : {hi, lo};
        quotFix = (signA_q ^ signB_q) ? -lo : lo;
        remFix  = signA_q ? -hi : hi;
        case (f3_q)
            F3_MUL:                        fixRes = prodFix[DWIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fixRes = prodFix[2*DWIDTH-1:DWIDTH];
            F3_DIV, F3_DIVU:               fixRes = quotFix;
            default:                       fixRes = remFix;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            f3_q     <= '0;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f3_q    <= funct3;
                        signA_q <= signA;
                        signB_q <= signB;
                        if (divZero || overflow) begin
                            result_q <= fastRes;
                            state_q  <= DONE;
                        end else begin
                            count_q <= CW'(DWIDTH - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (count_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                FIX: begin
                    result_q <= fixRes;
                    state_q  <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The issuing instruction is held in the same cycle start arrives, before the state changes.
    assign stall  = reset && (accept || (state_q == CALC) || (state_q == FIX));
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, stall window, results and corner cases.
module tb_muldiv_seq;

    localparam int DW = 32;

    logic          clock, reset, start;
    logic [2:0]    funct3;
    logic [DW-1:0] opa, opb;
    logic          stall, busy, done;
    logic [DW-1:0] result;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(.DWIDTH(DW)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .opa    (opa),
        .opb    (opb),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one op at a negedge and counts cycles until done; cycle 0 is the start cycle.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input bit hold, output int doneCycle, output int stallGaps,
                                 output logic [31:0] res, output logic stallAtDone);
        doneCycle   = -1;
        stallGaps   = 0;
        res         = '0;
        stallAtDone = 1'b1;
        @(negedge clock);
        funct3 = f3;
        opa    = a;
        opb    = b;
        start  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (done) begin
                doneCycle   = c;
                res         = result;
                stallAtDone = stall;
                break;
            end
            if (!stall) stallGaps++;
            @(negedge clock);
            if (!hold || (c + 1 >= DW + 2)) start = 1'b0;
            if (hold) begin
                opa = $urandom;
                opb = $urandom;
            end
        end
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit hold, input int expCycle,
                         input logic [31:0] expRes);
        int          cyc;
        int          gaps;
        logic [31:0] res;
        logic        sad;
        applyStimulus(f3, a, b, hold, cyc, gaps, res, sad);
        checkOutput({tag, " done cycle"}, 32'(cyc), 32'(expCycle));
        checkOutput({tag, " result"}, res, expRes);
        checkOutput({tag, " stall gaps"}, 32'(gaps), 32'd0);
        checkOutput({tag, " stall at done"}, {31'b0, sad}, 32'd0);
        @(negedge clock);
        #1;
        checkOutput({tag, " done after"}, {31'b0, done}, 32'd0);
        checkOutput({tag, " busy after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int extraDone;
        reset  = 1'b0;
        start  = 1'b1;
        funct3 = 3'b000;
        opa    = '0;
        opb    = '0;
        #12;
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        runOp("MUL 7*-3",       3'b000, 32'd7,        32'hFFFFFFFD, 1'b0, 34, 32'hFFFFFFEB);
        runOp("MULHU max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34, 32'hFFFFFFFE);
        runOp("MULH -1*-1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34, 32'h00000000);
        runOp("MULHSU -1*2",    3'b010, 32'hFFFFFFFF, 32'd2,        1'b0, 34, 32'hFFFFFFFF);
        runOp("DIV -20/3",      3'b100, 32'hFFFFFFEC, 32'd3,        1'b0, 34, 32'hFFFFFFFA);
        runOp("REM -20/3",      3'b110, 32'hFFFFFFEC, 32'd3,        1'b0, 34, 32'hFFFFFFFE);
        runOp("DIVU 20/3",      3'b101, 32'd20,       32'd3,        1'b0, 34, 32'd6);
        runOp("REMU 20/3",      3'b111, 32'd20,       32'd3,        1'b0, 34, 32'd2);
        runOp("DIVU 5/0",       3'b101, 32'd5,        32'd0,        1'b0, 1,  32'hFFFFFFFF);
        runOp("DIV 5/0",        3'b100, 32'd5,        32'd0,        1'b0, 1,  32'hFFFFFFFF);
        runOp("REM 7/0",        3'b110, 32'd7,        32'd0,        1'b0, 1,  32'd7);
        runOp("REM min/-1",     3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1,  32'h00000000);
        runOp("DIV min/-1",     3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1,  32'h80000000);
        runOp("MUL held start", 3'b000, 32'd6,        32'd7,        1'b1, 34, 32'd42);

        extraDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (done) extraDone++;
        end
        checkOutput("no extra done", 32'(extraDone), 32'd0);
        checkOutput("result holds", result, 32'd42);

        @(negedge clock);
        funct3 = 3'b100;
        opa    = 32'd100;
        opb    = 32'd7;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        checkOutput("busy before abort", {31'b0, busy}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        checkOutput("abort stall", {31'b0, stall}, 32'd0);
        checkOutput("abort done", {31'b0, done}, 32'd0);
        checkOutput("abort result", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        runOp("DIVU after abort", 3'b101, 32'd100, 32'd7, 1'b0, 34, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
